spi_byte_rx: RTL



---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_edge.sv | 75 +++++++
 rtl/spi_byte_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI byte receiver.
package spi_pkg;

    localparam int SPI_BITS_PER_BYTE = 8;
    localparam int SPI_CNT_W         = 3;

    // Receiver FSM: idle while deselected or disabled, receiving while selected.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// N-stage pin synchronizer with optional registered rise/fall pulses.
// STAGES is legal from 2 to 4. Set EDGE_EN to 0 when only the synchronized
// level is needed; the pulse outputs are then tied low.
// Latency: a pin transition appears on dout after STAGES clocks and on the
// pulse outputs after STAGES + 1 clocks.
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Next value of the shift chain: the pin enters at bit 0.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    // Synchronizer flops. They clear to 0 so that a deasserted chip select
    // has to be observed after reset before a new transfer can start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic hist_q;
            logic hist_d;
            logic rise_q;
            logic rise_d;
            logic fall_q;
            logic fall_d;

            // Compare the synchronized level with its one-cycle history.
            always_comb begin
                hist_d = dout;
                rise_d = dout & ~hist_q;
                fall_d = ~dout & hist_q;
            end

            // History flop and registered edge pulses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_q <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    hist_q <= hist_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign rise = rise_q;
            assign fall = fall_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver. It synchronizes the SPI pins, shifts bits
// in MSB-first on SCK rising edges, and reports each byte by toggling
// byte_finished while out_byte is updated on the same clock edge.
// Optional MISO transmitter is enabled by defining the SPI_TX_EN macro.
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic [7:0] out_byte,
    output logic       byte_finished,
    output logic       cs_active
);

    logic sck_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_n_s;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sck_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (spi_sck),
        .dout  (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (spi_cs_n),
        .dout  (cs_n_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_mosi_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (spi_mosi),
        .dout  (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_state_e                     state_q;
    spi_state_e                     state_d;
    logic [SPI_CNT_W-1:0]           cnt_q;
    logic [SPI_CNT_W-1:0]           cnt_d;
    logic [SPI_BITS_PER_BYTE-1:0]   shift_q;
    logic [SPI_BITS_PER_BYTE-1:0]   shift_d;
    logic [SPI_BITS_PER_BYTE-1:0]   out_q;
    logic [SPI_BITS_PER_BYTE-1:0]   out_d;
    logic                           bf_q;
    logic                           bf_d;
    logic                           armed_q;
    logic                           armed_d;
    logic                           byte_done;
    logic                           selected;

    // Selected means the synchronized chip select is low and the block is enabled.
    assign selected = ~cs_n_s & en;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a transfer may start only once chip select has been seen
    // high since reset, so a reset in mid-transfer waits for a fresh select.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (selected && armed_q) state_d = RECV;
            RECV:    if (!selected)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the FSM state.
    always_comb begin
        cs_active = (state_q == RECV);
    end

    // Receive datapath: shift on SCK rise while selected. Deselecting or
    // disabling clears the partial byte, and it also overrides a coincident
    // SCK edge.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        out_d     = out_q;
        bf_d      = bf_q;
        armed_d   = armed_q | cs_n_s;
        byte_done = 1'b0;
        if (state_q == RECV && selected) begin
            if (sck_rise) begin
                shift_d = {shift_q[SPI_BITS_PER_BYTE-2:0], mosi_s};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == SPI_CNT_W'(SPI_BITS_PER_BYTE - 1)) begin
                    out_d     = {shift_q[SPI_BITS_PER_BYTE-2:0], mosi_s};
                    bf_d      = ~bf_q;
                    byte_done = 1'b1;
                end
            end
        end else begin
            cnt_d   = '0;
            shift_d = '0;
        end
    end

    // Receive datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            bf_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            bf_q    <= bf_d;
            armed_q <= armed_d;
        end
    end

    assign out_byte      = out_q;
    assign byte_finished = bf_q;

`ifdef SPI_TX_EN
    logic [SPI_BITS_PER_BYTE-1:0] tx_q;
    logic [SPI_BITS_PER_BYTE-1:0] tx_d;
    logic                         skip_q;
    logic                         skip_d;
    logic                         unused_sig;

    // TX shifter: load on select and on each completed byte. After a byte
    // completes, the following SCK fall must not shift, so the freshly
    // loaded MSB is still on MISO for the next rising edge.
    always_comb begin
        tx_d   = tx_q;
        skip_d = skip_q;
        if (cs_fall) begin
            tx_d   = tx_byte;
            skip_d = 1'b0;
        end else if (byte_done) begin
            tx_d   = tx_byte;
            skip_d = 1'b1;
        end else if (state_q == RECV && sck_fall) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                tx_d = {tx_q[SPI_BITS_PER_BYTE-2:0], 1'b0};
            end
        end
    end

    // TX shifter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q   <= '0;
            skip_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            skip_q <= skip_d;
        end
    end

    assign spi_miso   = (state_q == RECV) ? tx_q[SPI_BITS_PER_BYTE-1] : 1'b0;
    assign unused_sig = cs_rise ^ sck_s;
`else
    logic unused_sig;

    assign spi_miso   = 1'b0;
    assign unused_sig = ^{tx_byte, sck_fall, cs_rise, cs_fall, sck_s, byte_done};
`endif

endmodule
